// File: rtl/alu_fu.sv
// ---------------------------------------------------------------------------
// alu_fu : pipelined integer ALU functional unit for the out-of-order back end
//
// Accepts one issued micro-op per cycle from the reservation station, computes
// one of ten integer operations and hands the result, its ROB tag and
// zero/sign flags to the CDB arbiter after STAGES cycles.  A plain
// valid/ready handshake on both sides gives full back-pressure, and a flush
// input kills everything in flight.
//
// Parameters
//   XLEN    operand/result width (8..64, power of two)
//   TAG_W   ROB tag width
//   STAGES  pipeline depth (1..4)
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   flush           kill all in-flight ops and the op offered this cycle
//   in_valid/ready  issue handshake from the reservation station
//   in_rs1/rs2/imm  operand A, register operand B, immediate operand B
//   in_alu_src      1 selects in_imm as operand B, 0 selects in_rs2
//   in_alu_ctrl     4-bit op select
//   in_tag          ROB tag travelling with the op
//   out_valid/ready result handshake towards the CDB arbiter
//   out_result      result, with out_zero / out_sign flags
//   out_tag         ROB tag of the result
//   out_illegal     the op select was not a defined encoding
//   perf_ops        delivered-op counter
//   perf_stall      back-pressure cycle counter
//
// Configuration
//   ALU_FU_PERF_EN  when defined, perf_ops/perf_stall are live 32-bit
//                   wrapping counters; otherwise they are tied to zero.
// ---------------------------------------------------------------------------
module alu_fu #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_alu_src,
  input  logic [3:0]       in_alu_ctrl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_sign,
  output logic             out_illegal,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SRA  = 4'b1110
  } alu_op_e;

  // Bit 0 is stage 1 (operand registers), bit STAGES-1 is the output stage.
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_adv;

  // Stage-1 registers
  logic             s1_valid;
  logic [XLEN-1:0]  s1_a;
  logic [XLEN-1:0]  s1_b;
  logic [3:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;

  // Combinational compute from stage 1
  logic [XLEN-1:0]  alu_res;
  logic             alu_ill;
  logic             alu_zero;
  logic             alu_sign;
  logic [SHW-1:0]   shamt;
  logic [XLEN-1:0]  op_b;

  // A stage may load whenever some stage at or below it (towards the output)
  // has room, or the CDB is taking the last result this cycle.  Written as a
  // running AND of occupancy so that out_ready reaches in_ready through pure
  // combinational logic and a full pipe still streams one op per cycle.
  always_comb begin
    logic all_full;
    all_full  = 1'b1;
    stage_adv = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      all_full     = all_full & stage_valid[i];
      stage_adv[i] = out_ready | ~all_full;
    end
  end

  assign in_ready = stage_adv[0];
  assign op_b     = in_alu_src ? in_imm : in_rs2;

  // Stage 1 captures operand A, the already-muxed operand B, op and tag.
  // Flush wins over a new capture, so an op offered in the flush cycle is
  // dropped even though in_ready may still read high.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_AND;
      s1_tag   <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (stage_adv[0]) begin
        s1_valid <= in_valid;
      end
      if (stage_adv[0] && in_valid) begin
        s1_a   <= in_rs1;
        s1_b   <= op_b;
        s1_op  <= in_alu_ctrl;
        s1_tag <= in_tag;
      end
    end
  end

  assign shamt = s1_b[SHW-1:0];

  // The ALU proper.  Undefined encodings pass operand A through and raise the
  // illegal flag so the ROB can raise the exception at commit.
  always_comb begin
    alu_res = s1_a;
    alu_ill = 1'b0;
    case (s1_op)
      OP_AND:  alu_res = s1_a & s1_b;
      OP_OR:   alu_res = s1_a | s1_b;
      OP_ADD:  alu_res = s1_a + s1_b;
      OP_XOR:  alu_res = s1_a ^ s1_b;
      OP_SLL:  alu_res = s1_a << shamt;
      OP_SRL:  alu_res = s1_a >> shamt;
      OP_SUB:  alu_res = s1_a - s1_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (s1_a < s1_b)};
      OP_SRA:  alu_res = XLEN'($signed(s1_a) >>> shamt);
      default: begin
        alu_res = s1_a;
        alu_ill = 1'b1;
      end
    endcase
  end

  assign alu_zero = (alu_res == '0);
  assign alu_sign = alu_res[XLEN-1];

  generate
    if (STAGES == 1) begin : g_single
      // Output stage is stage 1 itself; the compute result is shown directly.
      // Data outputs are qualified by valid so that the idle/reset view is an
      // all-zero bundle rather than the flags of the cleared operands.
      assign stage_valid = s1_valid;
      assign out_valid   = s1_valid;
      assign out_result  = s1_valid ? alu_res : '0;
      assign out_tag     = s1_valid ? s1_tag  : '0;
      assign out_zero    = s1_valid & alu_zero;
      assign out_sign    = s1_valid & alu_sign;
      assign out_illegal = s1_valid & alu_ill;
    end else begin : g_pipe
      localparam int N = STAGES - 1;

      logic [XLEN-1:0]  res_q   [N];
      logic [TAG_W-1:0] tag_q   [N];
      logic [N-1:0]     vld_q;
      logic [N-1:0]     zero_q;
      logic [N-1:0]     sign_q;
      logic [N-1:0]     ill_q;

      logic [XLEN-1:0]  src_res [N];
      logic [TAG_W-1:0] src_tag [N];
      logic [N-1:0]     src_vld;
      logic [N-1:0]     src_zero;
      logic [N-1:0]     src_sign;
      logic [N-1:0]     src_ill;

      // Each copy stage loads from its predecessor: the first one from the
      // compute logic, the rest from the copy stage just before it.
      always_comb begin
        src_res[0]  = alu_res;
        src_tag[0]  = s1_tag;
        src_vld[0]  = s1_valid;
        src_zero[0] = alu_zero;
        src_sign[0] = alu_sign;
        src_ill[0]  = alu_ill;
        for (int k = 1; k < N; k++) begin
          src_res[k]  = res_q[k-1];
          src_tag[k]  = tag_q[k-1];
          src_vld[k]  = vld_q[k-1];
          src_zero[k] = zero_q[k-1];
          src_sign[k] = sign_q[k-1];
          src_ill[k]  = ill_q[k-1];
        end
      end

      // Copy-stage registers.  Data moves only when the stage advances, which
      // keeps the output stage frozen while the CDB stalls.  Flush clears the
      // valids only; stale data is harmless because outputs are qualified.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q  <= '0;
          zero_q <= '0;
          sign_q <= '0;
          ill_q  <= '0;
          for (int k = 0; k < N; k++) begin
            res_q[k] <= '0;
            tag_q[k] <= '0;
          end
        end else begin
          for (int k = 0; k < N; k++) begin
            if (stage_adv[k+1]) begin
              vld_q[k]  <= src_vld[k];
              res_q[k]  <= src_res[k];
              tag_q[k]  <= src_tag[k];
              zero_q[k] <= src_zero[k];
              sign_q[k] <= src_sign[k];
              ill_q[k]  <= src_ill[k];
            end
          end
          if (flush) begin
            vld_q <= '0;
          end
        end
      end

      assign stage_valid = {vld_q, s1_valid};
      assign out_valid   = vld_q[N-1];
      assign out_result  = vld_q[N-1] ? res_q[N-1] : '0;
      assign out_tag     = vld_q[N-1] ? tag_q[N-1] : '0;
      assign out_zero    = vld_q[N-1] & zero_q[N-1];
      assign out_sign    = vld_q[N-1] & sign_q[N-1];
      assign out_illegal = vld_q[N-1] & ill_q[N-1];
    end
  endgenerate

`ifdef ALU_FU_PERF_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_stall_q;

  // Delivered ops and CDB stall cycles; both wrap and survive a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (out_valid && out_ready) begin
        perf_ops_q <= perf_ops_q + 32'd1;
      end
      if (out_valid && !out_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_ops   = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: doc/alu_fu.md
Name: alu_fu

Overview:
- Pipelined, parametrised integer ALU functional unit for the out-of-order back end.
- Accepts one issued micro-op per cycle from the reservation station over a valid/ready handshake.
- Computes one of ten ops and carries the ROB tag alongside the result.
- Delivers result plus zero/sign flags to the CDB arbiter after a fixed latency, with full back-pressure and flush support.

Parameters:
- XLEN, 32, operand/result width; 8..64, power of two.
- TAG_W, 6, ROB tag width.
- STAGES, 2, pipeline depth; 1..4.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill all in-flight ops and any op offered this cycle
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept this cycle
- in_rs1  in  XLEN  operand A
- in_rs2  in  XLEN  operand B (register)
- in_imm  in  XLEN  operand B (immediate, already sign-extended)
- in_alu_src  in  1  1 = B is in_imm, 0 = B is in_rs2
- in_alu_ctrl  in  4  op select
- in_tag  in  TAG_W  ROB tag
- out_valid  out  1  result available
- out_ready  in  1  CDB accepts result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  ROB tag of result
- out_zero  out  1  result == 0
- out_sign  out  1  result[XLEN-1]
- out_illegal  out  1  in_alu_ctrl was not a defined encoding
- perf_ops  out  32  retired-op count (see feature)
- perf_stall  out  32  back-pressure cycle count (see feature)

Behaviour:
- Op encodings:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, SRA 1110.
  - Any other encoding is illegal: result = A, out_illegal = 1.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - Shift amount = B[$clog2(XLEN)-1:0], upper bits ignored.
  - SRA replicates A[XLEN-1].
  - SLT is a signed compare, SLTU unsigned; result is 1 or 0, zero-extended.
- Flags:
  - out_zero = (result == 0); out_sign = result[XLEN-1]; both computed from the final result for every op.
  - out_zero and out_sign are never both 1.
- Datapath:
  - Stage 1 registers the operand-B mux output, op, tag and valid.
  - Compute is combinational from stage-1 registers.
  - Stages 2..STAGES are register copies of result/flags/tag/valid.
  - out_* are driven from the last stage.
- Handshake:
  - Transfer on in_valid && in_ready; transfer on out_valid && out_ready.
  - Stage i advances when it is empty or stage i+1 advances; the last stage advances on out_ready.
  - in_ready = stage 1 advances. The path from out_ready is combinational and has no bubble.
  - Throughput: 1 op/cycle when out_ready is held high.
- Latency:
  - Op accepted at edge k gives out_valid high after edge k+STAGES-1, with no back-pressure.
  - With STAGES=1, the result is visible in the cycle after accept.
- Back-pressure:
  - While out_valid && !out_ready, all out_* hold stable.
  - Upstream stages fill; in_ready drops only when every stage is occupied.
- Order: results leave in accept order.
- flush:
  - At the next edge all stage valids clear.
  - An op offered in the flush cycle is not captured.
  - in_ready is unaffected.
  - Data registers may hold stale values; out_valid = 0 the cycle after.
- Reset, including mid-operation, clears at the next edge:
  - all stage valids;
  - out_valid = 0, out_result = 0, out_tag = 0, out_zero = 0, out_sign = 0, out_illegal = 0;
  - perf counters = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset and flush together: reset dominates; same effect.
- Flush and out_ready together: the last-stage op is treated as delivered this cycle. The CDB takes it; the ROB discards by tag.

Optional Feature:
- Macro: ALU_FU_PERF_EN.
- Defined:
  - perf_ops increments on each out_valid && out_ready transfer.
  - perf_stall increments on each cycle with out_valid && !out_ready.
  - Both counters wrap at 2^32 and clear on reset; flush does not clear them.
- Undefined: perf_ops and perf_stall are tied to 0 and no counter flops are instantiated.

Test Plan:
- Ops at STAGES=2:
  - ADD 0x7FFFFFFF+1 gives result 0x80000000, sign=1, zero=0, out_valid at accept+1 edge.
  - SUB 5-5 gives result 0, zero=1, sign=0.
- Immediate and shifts:
  - alu_src=1, imm=0xFFFFFFFC, SRA of A=0x80000000 gives shamt 28 and result 0xFFFFFFF8.
  - SLL with B=33 shifts by 1.
- Compares and illegal op:
  - SLT(-1,1) = 1; SLTU(0xFFFFFFFF,1) = 0.
  - ctrl=1111 gives result = A, illegal=1.
- Back-pressure: stream tags 1..6 with out_ready low for 4 cycles.
  - in_ready drops after STAGES ops are held; outputs stay stable.
  - Tags emerge 1..6 in order with no loss or duplicate.
- Flush: flush with 2 ops in flight plus 1 offered.
  - No out_valid for those tags; the next op is accepted the following cycle.
- Reset mid-stream:
  - All outputs go 0 and in_ready=1 the next cycle.
  - With ALU_FU_PERF_EN, perf_ops=0 and perf_stall counts exactly the stalled cycles in the following run.
